// File: rtl/otter_alu_mdu.sv
// EX-stage ALU with RV32I functions and an iterative RV32M multiply/divide unit.
// Single-cycle results register directly; MUL/DIV share one shift/accumulate datapath.
module otter_alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_alu_fun,
    input  logic [XLEN-1:0] i_alu_src_a,
    input  logic [XLEN-1:0] i_alu_src_b,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_alu_out
);
    // state | meaning
    // IDLE  | no work held, ready to accept
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | result on o_alu_out, waiting for i_out_ready
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [SHAMT_W-1:0] r_cnt;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opb;
    logic [2:0]         r_f3;
    logic               r_neg;
    logic               r_neg_rem;

    logic               w_accept, w_is_m, w_is_div, w_last, w_one_cycle;
    logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic               w_div_zero, w_div_ovf, w_special;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_mag_a, w_mag_b, w_alu_res, w_special_res, w_load_res;
    logic [XLEN:0]      w_mul_sum, w_trial, w_diff;
    logic               w_qbit;
    logic [2*XLEN-1:0]  w_mul_next, w_prod, w_div_next;
    logic [XLEN-1:0]    w_mul_res, w_div_res, w_quo, w_rem;

    assign o_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready && !i_flush;
    assign w_last     = (r_cnt == '0);

    assign w_is_m     = i_alu_fun[4];
    assign w_is_div   = w_is_m && i_alu_fun[2];
    assign w_a_signed = w_is_div ? !i_alu_fun[0] : (i_alu_fun[1:0] == 2'b01 || i_alu_fun[1:0] == 2'b10);
    assign w_b_signed = w_is_div ? !i_alu_fun[0] : (i_alu_fun[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed && i_alu_src_a[XLEN-1];
    assign w_b_neg    = w_b_signed && i_alu_src_b[XLEN-1];
    assign w_mag_a    = w_a_neg ? -i_alu_src_a : i_alu_src_a;
    assign w_mag_b    = w_b_neg ? -i_alu_src_b : i_alu_src_b;

    assign w_div_zero    = (i_alu_src_b == '0);
    assign w_div_ovf     = !i_alu_fun[0] && (i_alu_src_a == MOST_NEG) && (i_alu_src_b == '1);
    assign w_special     = w_is_div && (w_div_zero || w_div_ovf);
    assign w_special_res = w_div_zero ? (i_alu_fun[1] ? i_alu_src_a : '1)
                                      : (i_alu_fun[1] ? '0 : i_alu_src_a);
    assign w_one_cycle   = !w_is_m || w_special;
    assign w_load_res    = w_is_m ? w_special_res : w_alu_res;
    assign w_shamt       = i_alu_src_b[SHAMT_W-1:0];

    always_comb begin
        w_alu_res = '0;
        case (i_alu_fun[3:0])
            4'b0000: w_alu_res = i_alu_src_a + i_alu_src_b;
            4'b1000: w_alu_res = i_alu_src_a - i_alu_src_b;
            4'b0110: w_alu_res = i_alu_src_a | i_alu_src_b;
            4'b0111: w_alu_res = i_alu_src_a & i_alu_src_b;
            4'b0100: w_alu_res = i_alu_src_a ^ i_alu_src_b;
            4'b0001: w_alu_res = i_alu_src_a << w_shamt;
            4'b0101: w_alu_res = i_alu_src_a >> w_shamt;
            4'b1101: w_alu_res = $unsigned($signed(i_alu_src_a) >>> w_shamt);
            4'b0010: w_alu_res = XLEN'($signed(i_alu_src_a) < $signed(i_alu_src_b));
            4'b0011: w_alu_res = XLEN'(i_alu_src_a < i_alu_src_b);
            4'b1001: w_alu_res = i_alu_src_a;
            default: w_alu_res = '0;
        endcase
    end

    // Multiply: r_acc = {partial high, remaining multiplier bits}, r_opb = multiplicand.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod     = r_neg ? -w_mul_next : w_mul_next;
    assign w_mul_res  = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // Divide: r_acc = {partial remainder, dividend shifting into quotient}, r_opb = divisor.
    assign w_trial    = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_trial - {1'b0, r_opb};
    assign w_qbit     = !w_diff[XLEN];
    assign w_div_next = {(w_qbit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0]), r_acc[XLEN-2:0], w_qbit};
    assign w_quo      = w_div_next[XLEN-1:0];
    assign w_rem      = w_div_next[2*XLEN-1:XLEN];
    assign w_div_res  = r_f3[1] ? (r_neg_rem ? -w_rem : w_rem) : (r_neg ? -w_quo : w_quo);

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
            if (w_one_cycle)   w_state_nxt = ST_DONE;
            else if (w_is_div) w_state_nxt = ST_DIV;
            else               w_state_nxt = ST_MUL;
        end else begin
            case (r_state)
                ST_MUL, ST_DIV: if (w_last) w_state_nxt = ST_DONE;
                ST_DONE:        if (i_out_ready) w_state_nxt = ST_IDLE;
                default:        w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            o_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            o_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_f3      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            o_alu_out <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt     <= SHAMT_W'(XLEN-1);
            r_f3      <= i_alu_fun[2:0];
            r_neg     <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_opb     <= w_is_div ? w_mag_b : w_mag_a;
            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            if (w_one_cycle) o_alu_out <= w_load_res;
        end else if (r_state == ST_MUL || r_state == ST_DIV) begin
            r_acc <= (r_state == ST_MUL) ? w_mul_next : w_div_next;
            if (w_last) o_alu_out <= (r_state == ST_MUL) ? w_mul_res : w_div_res;
            else        r_cnt     <= r_cnt - SHAMT_W'(1);
        end
    end
endmodule

// File: tb/tb_otter_alu_mdu.sv
// Self-checking bench for otter_alu_mdu: vector table, random ops against a
// 64-bit arithmetic reference model, and handshake/flush/reset sequences.
module tb_otter_alu_mdu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [4:0]  fun;
    logic [31:0] a, b;
    logic        in_ready, out_valid;
    logic [31:0] alu_out;

    logic        in_valid16, flush16, out_ready16;
    logic [4:0]  fun16;
    logic [15:0] a16, b16;
    logic        in_ready16, out_valid16;
    logic [15:0] alu_out16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    otter_alu_mdu #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_alu_fun(fun), .i_alu_src_a(a), .i_alu_src_b(b), .i_flush(flush),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_alu_out(alu_out));

    otter_alu_mdu #(.XLEN(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid16), .o_in_ready(in_ready16),
        .i_alu_fun(fun16), .i_alu_src_a(a16), .i_alu_src_b(b16), .i_flush(flush16),
        .o_out_valid(out_valid16), .i_out_ready(out_ready16), .o_alu_out(alu_out16));

    localparam logic [4:0] F_ADD = 5'b00000, F_SUB = 5'b01000, F_OR = 5'b00110, F_AND = 5'b00111,
                           F_XOR = 5'b00100, F_SLL = 5'b00001, F_SRL = 5'b00101, F_SRA = 5'b01101,
                           F_SLT = 5'b00010, F_SLTU = 5'b00011, F_LUI = 5'b01001,
                           F_MUL = 5'b10000, F_MULH = 5'b10001, F_MULHSU = 5'b10010, F_MULHU = 5'b10011,
                           F_DIV = 5'b10100, F_DIVU = 5'b10101, F_REM = 5'b10110, F_REMU = 5'b10111;

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t strm[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V semantics from 64-bit products and native signed division.
    function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        logic [63:0] px, py, p;
        logic [31:0] q, r;
        sx = x;
        sy = y;
        if (!f[4]) begin
            case (f[3:0])
                4'b0000: return x + y;
                4'b1000: return x - y;
                4'b0110: return x | y;
                4'b0111: return x & y;
                4'b0100: return x ^ y;
                4'b0001: return x << y[4:0];
                4'b0101: return x >> y[4:0];
                4'b1101: begin sx = sx >>> y[4:0]; return sx; end
                4'b0010: return (sx < sy) ? 32'd1 : 32'd0;
                4'b0011: return (x < y) ? 32'd1 : 32'd0;
                4'b1001: return x;
                default: return 32'd0;
            endcase
        end
        if (!f[2]) begin
            px = (f[1:0] == 2'b01 || f[1:0] == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
            py = (f[1:0] == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
            p  = px * py;
            return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
        end
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF; r = x;
        end else if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x; r = 32'd0;
        end else if (!f[0]) begin
            q = sx / sy; r = sx % sy;
        end else begin
            q = x / y; r = x % y;
        end
        return f[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[4]) return 0;
        if (f[2] && (y == 32'd0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 0;
        return 32;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with OUT_READY=1 and check latency (edges after accept) and result.
    task automatic do_op(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        @(negedge clk);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; fun = f; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; fun = 5'($urandom); a = $urandom; b = $urandom;
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, alu_out, exp);
    endtask

    task automatic do_op16(input logic [4:0] f, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] exp, input string name);
        int lat;
        @(negedge clk);
        in_valid16 = 1'b1; fun16 = f; a16 = x; b16 = y;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        @(negedge clk);
        lat = 0;
        while (!out_valid16 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd16);
        check({name, " result"}, 32'(alu_out16), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic seen;
        logic [4:0]  rf;
        logic [31:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        fun = '0; a = '0; b = '0;
        in_valid16 = 1'b0; flush16 = 1'b0; out_ready16 = 1'b1;
        fun16 = '0; a16 = '0; b16 = '0;

        vecs.push_back('{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "MULH min*min"});
        vecs.push_back('{F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "MULHSU -1*max"});
        vecs.push_back('{F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, "MUL 7*-3"});
        vecs.push_back('{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "MULHU max*max"});
        vecs.push_back('{F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, "DIV -7/2"});
        vecs.push_back('{F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, "REM -7/2"});
        vecs.push_back('{F_DIVU,   32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 0,  "DIVU x/0"});
        vecs.push_back('{F_REM,    32'd9,         32'd0,         32'd9,         0,  "REM 9/0"});
        vecs.push_back('{F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  "DIV min/-1"});
        vecs.push_back('{F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0,  "REM min/-1"});
        vecs.push_back('{5'b11101, 32'd100,       32'd7,         32'd14,        32, "DIVU f7 ignored"});
        vecs.push_back('{F_REMU,   32'd100,       32'd7,         32'd2,         32, "REMU 100/7"});
        vecs.push_back('{F_OR,     32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0,  "OR"});
        vecs.push_back('{F_AND,    32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0,  "AND"});
        vecs.push_back('{F_XOR,    32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0,  "XOR"});
        vecs.push_back('{F_SLL,    32'd1,         32'h0000_0021, 32'd2,         0,  "SLL shamt wrap"});
        vecs.push_back('{F_SRL,    32'h8000_0000, 32'd31,        32'd1,         0,  "SRL 31"});
        vecs.push_back('{F_LUI,    32'h1234_5000, 32'hDEAD_BEEF, 32'h1234_5000, 0,  "LUI pass A"});
        vecs.push_back('{5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         0,  "undefined op"});

        strm.push_back('{F_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 0, "stream SUB"});
        strm.push_back('{F_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 0, "stream SRA"});
        strm.push_back('{F_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         0, "stream SLT"});
        strm.push_back('{F_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, "stream SLTU"});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset alu_out", alu_out, 32'd0);
        rst_n = 1'b1;
        #1 check("reset in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        for (int n = 0; n < 80; n++) begin
            rf = 5'($urandom_range(0, 31));
            ra = rnd_operand();
            rb = rnd_operand();
            do_op(rf, ra, rb, ref_alu(rf, ra, rb), ref_lat(rf, ra, rb), "random");
        end

        // Back-to-back single-cycle ops: one result per cycle.
        @(negedge clk);
        foreach (strm[i]) begin
            check({strm[i].name, " in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1; fun = strm[i].f; a = strm[i].a; b = strm[i].b;
            @(posedge clk);
            @(negedge clk);
            check({strm[i].name, " out_valid"}, 32'(out_valid), 32'd1);
            check(strm[i].name, alu_out, strm[i].exp);
        end
        in_valid = 1'b0;

        // Backpressure on a DIVU result, then simultaneous consume + accept.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; fun = F_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp DIVU latency", 32'(lat), 32'd32);
        check("bp DIVU result", alu_out, 32'd14);
        in_valid = 1'b1; fun = F_ADD; a = 32'd10; b = 32'd20;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp held out_valid", 32'(out_valid), 32'd1);
            check("bp held alu_out", alu_out, 32'd14);
            check("bp in_ready low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1 check("bp in_ready on ack", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp ADD out_valid", 32'(out_valid), 32'd1);
        check("bp ADD result", alu_out, 32'd30);

        // Flush mid-divide.
        @(negedge clk);
        in_valid = 1'b1; fun = F_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush no late result", 32'(seen), 32'd0);
        do_op(F_DIVU, 32'd1000, 32'd10, 32'd100, 32, "after flush DIVU");

        // Flush coinciding with an accept drops that op.
        @(negedge clk);
        in_valid = 1'b1; fun = F_ADD; a = 32'd1; b = 32'd2; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush+accept out_valid", 32'(out_valid), 32'd0);
        check("flush+accept in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush+accept no result", 32'(seen), 32'd0);

        // Reset at iteration 10 of a multiply.
        @(negedge clk);
        in_valid = 1'b1; fun = F_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", 32'(out_valid), 32'd0);
        check("mid-reset alu_out", alu_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post-reset in_ready", 32'(in_ready), 32'd1);
        do_op(F_ADD, 32'd5, 32'd7, 32'd12, 0, "post-reset ADD");

        // XLEN=16 instance: flush a divide, then 16-cycle multiply/remainder.
        @(negedge clk);
        in_valid16 = 1'b1; fun16 = F_DIV; a16 = 16'd100; b16 = 16'd3;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        flush16 = 1'b1;
        @(posedge clk); #1;
        flush16 = 1'b0;
        @(negedge clk);
        check("x16 flush out_valid", 32'(out_valid16), 32'd0);
        check("x16 flush in_ready", 32'(in_ready16), 32'd1);
        do_op16(F_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, "x16 MULHU");
        do_op16(F_REM, 16'hFFF9, 16'd2, 16'hFFFF, "x16 REM -7/2");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/otter_alu_mdu.md
# otter_alu_mdu

Parametrised, handshaked successor to the OTTER single-cycle ALU. Executes all RV32I ALU functions plus the full RV32M multiply/divide set. Single-cycle functions have a registered one-cycle result; multiply and divide run on a shared iterative datapath. Sits in the EX stage; IN_READY stalls the pipeline and FLUSH drops wrong-path work.

## Interface
- XLEN, 32: operand/result width; power of two, ≥8.
- SHAMT_W, $clog2(XLEN): shift-amount width; derived, not overridden.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operands/function valid this cycle.
- IN_READY  output  1  unit can accept; transfer on IN_VALID && IN_READY at a rising edge.
- ALU_FUN  input  5  {m_ext, func7[5], func3[2:0]}.
- ALU_SRC_A  input  XLEN  operand A.
- ALU_SRC_B  input  XLEN  operand B.
- FLUSH  input  1  synchronous abort of in-flight or held operation.
- OUT_VALID  output  1  ALU_OUT holds a result.
- OUT_READY  input  1  consumer accepts result.
- ALU_OUT  output  XLEN  result; held stable while OUT_VALID && !OUT_READY.

## Operation
- Single-cycle ops, ALU_FUN[4]=0:
  - 0000 add; 1000 sub; 0110 or; 0111 and; 0100 xor.
  - 0001 sll; 0101 srl; 1101 sra (true sign fill). Shifts use B[SHAMT_W-1:0].
  - 0010 slt (signed); 0011 sltu; 1001 pass A (lui).
  - Any other code with [4]=0 returns 0.
- M ops, ALU_FUN[4]=1, [3] ignored:
  - func3 000 MUL (low XLEN); 001 MULH (s×s high); 010 MULHSU (s×u high); 011 MULHU (u×u high).
  - func3 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- States:
  - IDLE: IN_READY=1.
  - MUL: shift-add multiply.
  - DIV: restoring divide.
  - DONE: OUT_VALID=1.
- Transitions:
  - Accept of a single-cycle op, or a divide special case → DONE.
  - Accept of a multiply → MUL. Accept of a normal divide → DIV.
  - MUL/DIV → DONE on the last iteration.
  - DONE with OUT_READY, no new accept → IDLE.
  - DONE with OUT_READY and a new accept → proceed as on accept from IDLE.
- IN_READY = IDLE || (DONE && OUT_READY). IN_READY=0 in MUL/DIV and in DONE while unacknowledged.
- Operands and function are captured at accept; later input changes are ignored.
- Multiply datapath:
  - Operate on magnitudes, per-op signedness. 2·XLEN-bit accumulator, one multiplier bit per cycle, XLEN iterations.
  - Negate the 2·XLEN product if the signs differ, then select the low or high half.
- Divide datapath:
  - Magnitudes, one quotient bit per cycle, XLEN iterations.
  - Quotient sign = sign(A)^sign(B). Remainder sign = sign(A) (signed ops only).
- Divide special cases (single-cycle path, straight to DONE):
  - B=0: quotient all ones; remainder = A (both signed and unsigned).
  - Signed A=most-negative, B=−1: quotient = A; remainder = 0.
- FLUSH: forces IDLE and OUT_VALID=0 at the next edge and discards any result. An accept in the same cycle is also discarded. IN_READY is 1 the cycle after.
- Reset (any time, including mid-iteration): state IDLE, iteration counter 0, OUT_VALID=0, ALU_OUT=0, IN_READY=1 once RST_N is deasserted.

## Timing
- Accept at edge N, single-cycle op: OUT_VALID=1 and ALU_OUT valid from edge N (visible in cycle N+1).
- Multiply, or non-special divide: OUT_VALID from edge N+XLEN (32 cycles at XLEN=32). Fixed latency, no early termination.
- Back-to-back single-cycle ops with OUT_READY held 1: one result per cycle, no bubbles.
- Result held with no handshake timeout: OUT_VALID and ALU_OUT are stable until the OUT_READY edge.
- All outputs are registered except IN_READY, which is combinational from state and OUT_READY.

## Test plan
- Reset mid-multiply: accept MULHU 0xFFFFFFFF×0xFFFFFFFF, assert RST_N=0 at iteration 10 → OUT_VALID=0, ALU_OUT=0 immediately. Then accept ADD 5+7 → 12 one cycle after accept.
- Stream with OUT_READY=1: SUB 3−5 → 0xFFFFFFFE; SRA 0x80000000>>4 → 0xF8000000; SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0. One result per cycle.
- MULH 0x80000000×0x80000000 → 0x40000000 at exactly edge N+32. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 7×−3 → 0xFFFFFFEB.
- Divide corners:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU x/0 → 0xFFFFFFFF; REM 9/0 → 9. Both with 1-cycle latency.
  - DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0.
- Backpressure: hold OUT_READY=0 for 5 cycles after a DIVU result → ALU_OUT stable, IN_READY=0, and a new IN_VALID is not accepted. Raise OUT_READY with a new ADD presented → both transfers occur at the same edge.
- FLUSH at iteration 20 of DIV → OUT_VALID stays 0, IN_READY=1 next cycle, next op's result correct. Repeat at XLEN=16 with MULHU 0xFFFF×0xFFFF → 0xFFFE after 16 cycles.
